// File: rtl/reflet_float_issue.sv
// Issue stage for a multi-cycle FPU: accepts one operation, holds the FPU
// operands steady for the op's latency, then presents the result until taken.
module reflet_float_issue #(
   parameter int float_size = 16,
   parameter int lat_add    = 1,
   parameter int lat_sub    = 1,
   parameter int lat_mul    = 2,
   parameter int lat_div    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [float_size-1:0] req_a,
   input  logic [float_size-1:0] req_b,
   output logic [1:0]            fpu_op,
   output logic [float_size-1:0] fpu_a,
   output logic [float_size-1:0] fpu_b,
   output logic                  fpu_enable,
   input  logic [float_size-1:0] fpu_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [float_size-1:0] rsp_result
);

   function automatic int eff_lat(input int l);
      return (l < 1) ? 1 : l;
   endfunction

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   localparam int EL_ADD  = eff_lat(lat_add);
   localparam int EL_SUB  = eff_lat(lat_sub);
   localparam int EL_MUL  = eff_lat(lat_mul);
   localparam int EL_DIV  = eff_lat(lat_div);
   localparam int MAX_LAT = max2(max2(EL_ADD, EL_SUB), max2(EL_MUL, EL_DIV));
   localparam int CW      = $clog2(MAX_LAT) + 1;

   localparam logic [CW-1:0] LM1_ADD = CW'(EL_ADD - 1);
   localparam logic [CW-1:0] LM1_SUB = CW'(EL_SUB - 1);
   localparam logic [CW-1:0] LM1_MUL = CW'(EL_MUL - 1);
   localparam logic [CW-1:0] LM1_DIV = CW'(EL_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_count_next;
   logic [CW-1:0]         w_lat_m1;
   logic                  w_load;
   logic                  w_capture;
   logic [1:0]            r_fpu_op;
   logic [float_size-1:0] r_fpu_a;
   logic [float_size-1:0] r_fpu_b;
   logic [float_size-1:0] r_rsp_result;

   // Terminal count is chosen from the latched opcode, not the live request.
   always_comb begin
      case (r_fpu_op)
         2'd0:    w_lat_m1 = LM1_ADD;
         2'd1:    w_lat_m1 = LM1_SUB;
         2'd2:    w_lat_m1 = LM1_MUL;
         default: w_lat_m1 = LM1_DIV;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_load       = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_next = S_WAIT;
               w_count_next = '0;
               w_load       = 1'b1;
            end
         end
         S_WAIT: begin
            if (r_count == w_lat_m1) begin
               w_capture    = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_count_next = r_count + CW'(1);
            end
         end
         S_DONE: begin
            if (rsp_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_fpu_op     <= '0;
         r_fpu_a      <= '0;
         r_fpu_b      <= '0;
         r_rsp_result <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_load) begin
            r_fpu_op <= req_op;
            r_fpu_a  <= req_a;
            r_fpu_b  <= req_b;
         end
         if (w_capture) r_rsp_result <= fpu_result;
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign fpu_enable = (r_state == S_WAIT);
   assign rsp_valid  = (r_state == S_DONE);
   assign fpu_op     = r_fpu_op;
   assign fpu_a      = r_fpu_a;
   assign fpu_b      = r_fpu_b;
   assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_reflet_float_issue.sv
// Scoreboard bench for reflet_float_issue with a latency-accurate FPU model;
// a second instance with lat_mul=0 covers the zero-latency clamp.
module tb_reflet_float_issue;

   typedef struct {
      logic [15:0] res;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, fpu_enable, rsp_valid, rsp_ready;
   logic [1:0]  req_op, fpu_op;
   logic [15:0] req_a, req_b, fpu_a, fpu_b, fpu_result, rsp_result;

   logic        z_req_valid, z_req_ready, z_fpu_enable, z_rsp_valid, z_rsp_ready;
   logic [1:0]  z_req_op, z_fpu_op;
   logic [15:0] z_req_a, z_req_b, z_fpu_a, z_fpu_b, z_fpu_result, z_rsp_result;

   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   m_cnt  = 0;
   int   z_cnt  = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reflet_float_issue #(.float_size(16), .lat_add(1), .lat_sub(1), .lat_mul(2), .lat_div(8)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_enable(fpu_enable),
      .fpu_result(fpu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result));

   reflet_float_issue #(.float_size(16), .lat_add(1), .lat_sub(1), .lat_mul(0), .lat_div(8)) u_dut_z (
      .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_op(z_req_op), .req_a(z_req_a), .req_b(z_req_b),
      .fpu_op(z_fpu_op), .fpu_a(z_fpu_a), .fpu_b(z_fpu_b), .fpu_enable(z_fpu_enable),
      .fpu_result(z_fpu_result), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
      .rsp_result(z_rsp_result));

   // Hand-computed half-precision results for the directed vectors.
   function automatic logic [15:0] fpu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      if (op == 2'd0 && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
      if (op == 2'd0 && a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
      if (op == 2'd0 && a == 16'h4000 && b == 16'h4000) return 16'h4400;
      if (op == 2'd1 && a == 16'h4200 && b == 16'h3C00) return 16'h4000;
      if (op == 2'd2 && a == 16'h4000 && b == 16'h4200) return 16'h4600;
      if (op == 2'd3 && a == 16'h4200 && b == 16'h3C00) return 16'h4200;
      return a ^ b;
   endfunction

   function automatic int lat_main(input logic [1:0] op);
      case (op)
         2'd0: return 1;
         2'd1: return 1;
         2'd2: return 2;
         default: return 8;
      endcase
   endfunction

   // The model only shows the true result from its L-th enabled cycle on.
   always @(posedge clk) m_cnt <= fpu_enable ? m_cnt + 1 : 0;
   always @(posedge clk) z_cnt <= z_fpu_enable ? z_cnt + 1 : 0;
   assign fpu_result   = (fpu_enable && m_cnt >= lat_main(fpu_op) - 1) ? fpu_f(fpu_op, fpu_a, fpu_b) : 16'hBAD0;
   assign z_fpu_result = (z_fpu_enable && z_cnt >= ((z_fpu_op == 2'd2) ? 1 : lat_main(z_fpu_op)) - 1)
                         ? fpu_f(z_fpu_op, z_fpu_a, z_fpu_b) : 16'hBAD0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         $display("  ok %s: %0h (cycle %0d)", nm, act, cyc);
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!req_ready && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 40) check("req_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
      exp_t e;
      @(posedge clk); #1;
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      wait_ready();
      if (push) begin
         e.res = fpu_f(op, a, b);
         e.lat = lat_main(op);
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Monitor: pops on each rsp_valid rise; also checks hold and operand stability.
   initial begin
      exp_t        e;
      bit          have_acc = 0;
      bit          prev_valid = 0;
      int          acc_cyc = 0;
      logic [15:0] acc_a = '0, acc_b = '0, held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            have_acc   = 0;
            prev_valid = 0;
         end else begin
            if (rsp_valid && !prev_valid) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("rsp_result", 32'(rsp_result), 32'(e.res));
                  check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
               end
               held = rsp_result;
            end else if (rsp_valid) begin
               check("rsp_held", 32'(rsp_result), 32'(held));
               check("ready_low_in_done", 32'(req_ready), 32'd0);
            end
            if (have_acc && !req_ready) begin
               check("fpu_a_stable", 32'(fpu_a), 32'(acc_a));
               check("fpu_b_stable", 32'(fpu_b), 32'(acc_b));
            end
            if (req_valid && req_ready) begin
               have_acc = 1;
               acc_cyc  = cyc + 1;
               acc_a    = req_a;
               acc_b    = req_b;
            end
            prev_valid = rsp_valid;
         end
      end
   end

   initial begin
      int c1, c2, t;
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      z_req_valid = 1'b0; z_req_op = '0; z_req_a = '0; z_req_b = '0; z_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_fpu_op", 32'(fpu_op), 32'd0);
      check("rst_fpu_a", 32'(fpu_a), 32'd0);
      check("rst_fpu_b", 32'(fpu_b), 32'd0);
      check("rst_fpu_enable", 32'(fpu_enable), 32'd0);

      issue(2'd0, 16'h3C00, 16'h4000, 1);
      issue(2'd1, 16'h4200, 16'h3C00, 1);
      issue(2'd2, 16'h4000, 16'h4200, 1);
      issue(2'd3, 16'h4200, 16'h3C00, 1);

      // Backpressure with a competing request that must be ignored.
      wait_ready();
      rsp_ready = 1'b0;
      issue(2'd0, 16'h3C00, 16'h3C00, 1);
      t = 0;
      while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
      req_op = 2'd2; req_a = 16'h1234; req_b = 16'h5678; req_valid = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", 32'(rsp_result), 32'h4000);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_released_ready", 32'(req_ready), 32'd1);
      check("bp_ignored_req", 32'(fpu_a), 32'h3C00);

      // Abort a mul one cycle into WAIT.
      issue(2'd2, 16'h4000, 16'h4200, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_rsp_result", 32'(rsp_result), 32'd0);
      check("abort_fpu_op", 32'(fpu_op), 32'd0);
      check("abort_fpu_a", 32'(fpu_a), 32'd0);
      check("abort_fpu_b", 32'(fpu_b), 32'd0);
      check("abort_fpu_enable", 32'(fpu_enable), 32'd0);
      reset = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      check("abort_idle_after", 32'(req_ready), 32'd1);

      // Back-to-back adds with req_valid held high.
      req_op = 2'd0; req_a = 16'h3C00; req_b = 16'h4000; req_valid = 1'b1;
      wait_ready();
      c1 = cyc + 1;
      sb_q.push_back('{res: 16'h4200, lat: 1});
      @(posedge clk); #1;
      req_a = 16'h4000; req_b = 16'h4000;
      wait_ready();
      c2 = cyc + 1;
      sb_q.push_back('{res: 16'h4400, lat: 1});
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b_interval", 32'(c2 - c1), 32'd3);

      // Zero-latency mul on the second instance.
      z_req_op = 2'd2; z_req_a = 16'h4000; z_req_b = 16'h4200; z_req_valid = 1'b1;
      check("z_req_ready", 32'(z_req_ready), 32'd1);
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      check("z_enable_e0", 32'(z_fpu_enable), 32'd1);
      check("z_rsp_valid_e0", 32'(z_rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("z_rsp_valid_e1", 32'(z_rsp_valid), 32'd1);
      check("z_rsp_result", 32'(z_rsp_result), 32'h4600);

      t = 0;
      while (sb_q.size() != 0 && t < 30) begin @(posedge clk); #1; t++; end
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/reflet_float_issue.md
REFLET_FLOAT_ISSUE -- requirements
Module: reflet_float_issue

Interface
REQ-001 SHALL have parameter float_size, default 16: width of operands and result.
REQ-002 SHALL have parameter lat_add, default 1: cycles the FPU needs for op 0 (add).
REQ-003 SHALL have parameter lat_sub, default 1: cycles the FPU needs for op 1 (sub).
REQ-004 SHALL have parameter lat_mul, default 2: cycles the FPU needs for op 2 (mul).
REQ-005 SHALL have parameter lat_div, default 8: cycles the FPU needs for op 3 (div).
REQ-006 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port: req_valid  input  1  requester offers an operation.
REQ-009 SHALL have port: req_ready  output  1  block can accept an operation.
REQ-010 SHALL have port: req_op  input  2  opcode: 0 add, 1 sub, 2 mul, 3 div.
REQ-011 SHALL have ports: req_a, req_b  input  float_size  operands.
REQ-012 SHALL have port: fpu_op  output  2  opcode driven to the FPU.
REQ-013 SHALL have ports: fpu_a, fpu_b  output  float_size  operands driven to the FPU.
REQ-014 SHALL have port: fpu_enable  output  1  high while an operation is in flight.
REQ-015 SHALL have port: fpu_result  input  float_size  FPU result.
REQ-016 SHALL have port: rsp_valid  output  1  rsp_result holds a finished result.
REQ-017 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-018 SHALL have port: rsp_result  output  float_size  captured result.

Function
REQ-019 SHALL implement a 3-state FSM: IDLE, WAIT, DONE.
REQ-020 SHALL drive req_ready = 1 only in IDLE, combinationally from state.
REQ-021 In IDLE with req_valid=1, SHALL latch req_op/req_a/req_b into fpu_op/fpu_a/fpu_b, clear counter, and enter WAIT (acceptance edge E0).
REQ-022 In IDLE with req_valid=0, SHALL remain in IDLE with fpu_* unchanged.
REQ-023 SHALL drive fpu_enable = 1 in WAIT only.
REQ-024 SHALL keep fpu_op/fpu_a/fpu_b constant from E0 until the next acceptance, so FPU inputs never glitch during or after an operation.
REQ-025 Effective latency L = parameter for latched fpu_op; a parameter value of 0 SHALL be treated as 1.
REQ-026 In WAIT, at each edge: if counter == L-1, SHALL capture fpu_result into rsp_result and enter DONE; otherwise counter += 1.
REQ-027 Consequently rsp_result SHALL equal fpu_result sampled at the L-th rising edge after E0, and rsp_valid SHALL rise immediately after that edge.
REQ-028 Counter width SHALL be $clog2(max latency)+1 bits; it SHALL never wrap.
REQ-029 req_valid, req_op, req_a, req_b SHALL be ignored outside IDLE.
REQ-030 SHALL drive rsp_valid = 1 in DONE only; rsp_result SHALL be held stable while rsp_valid=1.
REQ-031 In DONE with rsp_ready=1, SHALL enter IDLE; rsp_result keeps its value afterwards.
REQ-032 In DONE with rsp_ready=0, SHALL stay in DONE indefinitely (backpressure).
REQ-033 rsp_ready while not in DONE SHALL have no effect.
REQ-034 Minimum issue-to-issue interval SHALL be L+2 cycles (accept, L waits, handoff).

Reset
REQ-035 reset=1 at an edge SHALL force state IDLE, counter 0, rsp_valid 0, rsp_result 0, fpu_op 0, fpu_a 0, fpu_b 0, fpu_enable 0; reset has priority over all other inputs.
REQ-036 Reset in WAIT or DONE SHALL abort the operation; the aborted result SHALL never appear with rsp_valid=1.
REQ-037 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 Add: bench FPU model, req_op=0, a=0x3C00, b=0x4000 -> fpu_enable high 1 cycle, rsp_valid 1 cycle after E0, rsp_result=0x4200.
REQ-039 Div, lat_div=8: req_op=3, a=0x4200, b=0x3C00 -> rsp_valid exactly 8 cycles after E0, fpu_a/fpu_b stable throughout, rsp_result=0x4200.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_result held, req_ready=0, a new req_valid is ignored.
REQ-041 Reset mid-WAIT of a mul: assert reset at cycle 1 after E0 -> next cycle all outputs are at reset values, no rsp_valid ever seen for that op.
REQ-042 Back-to-back: req_valid held high with rsp_ready=1, two adds -> second accepted 3 cycles after first (L=1), results in order.
REQ-043 Zero latency: lat_mul=0, mul request -> behaves as L=1, rsp_valid 1 cycle after E0.
